// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the two-requester block-RAM arbiter.
package ram_arb_pkg;

    localparam int AW_DEFAULT = 10;
    localparam int DW_DEFAULT = 8;

    // Polarity of the RAM rw pin.
    localparam logic RAM_READ  = 1'b1;
    localparam logic RAM_WRITE = 1'b0;

    // Requester identity, used by the round-robin pointer and the response tags.
    typedef enum logic {
        REQ_A = 1'b0,
        REQ_B = 1'b1
    } req_id_t;

endpackage : ram_arb_pkg

// File: rtl/rr_grant2.sv
// Two-input round-robin grant. The requester that did not win the most recent
// transfer has priority when both are valid; no grant is issued during reset.
module rr_grant2
    import ram_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] valid,   // [0] = A, [1] = B
    input  logic       accept,  // a transfer happened this cycle
    output logic [1:0] grant    // one-hot, [0] = A, [1] = B
);

    req_id_t last_q;
    req_id_t last_d;

    // Grant selection and pointer update; no dependency on the requesters' ready.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        grant  = 2'b00;
        last_d = last_q;
        if (!rst) begin
            unique case (valid)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = (last_q == REQ_B) ? 2'b01 : 2'b10;
                default: grant = 2'b00;
            endcase
        end
        if (accept) begin
            last_d = grant[1] ? REQ_B : REQ_A;
        end
    end

    // Round-robin pointer; resetting to B lets A win the first contention.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignment so all flops update together.
        if (rst) begin
            last_q <= REQ_B;
        end else begin
            last_q <= last_d;
        end
    end

endmodule : rr_grant2

// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one single-port block RAM between requesters A
// and B. The winning command is registered onto the RAM pins; a two-deep tag
// pipeline routes the read data back to its owner two cycles after acceptance.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int AW = AW_DEFAULT,
    parameter int DW = DW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          a_valid,
    output logic          a_ready,
    input  logic          a_we,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_wdata,
    output logic          a_rd_valid,
    output logic [DW-1:0] a_rd_data,

    input  logic          b_valid,
    output logic          b_ready,
    input  logic          b_we,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_wdata,
    output logic          b_rd_valid,
    output logic [DW-1:0] b_rd_data,

    output logic [AW-1:0] ram_addr,
    output logic          ram_rw,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata
);

    logic [1:0] grant;
    logic       xfer_a;
    logic       xfer_b;
    logic       xfer_any;

    logic [AW-1:0] ram_addr_q,  ram_addr_d;
    logic          ram_rw_q,    ram_rw_d;
    logic [DW-1:0] ram_wdata_q, ram_wdata_d;

    logic    s1_vld_q, s1_vld_d;
    req_id_t s1_own_q, s1_own_d;
    logic    s1_rd_q,  s1_rd_d;
    logic    s2_vld_q, s2_vld_d;
    req_id_t s2_own_q, s2_own_d;
    logic    s2_rd_q,  s2_rd_d;

    rr_grant2 u_grant (
        .clk    (clk),
        .rst    (rst),
        .valid  ({b_valid, a_valid}),
        .accept (xfer_any),
        .grant  (grant)
    );

    assign a_ready  = grant[0];
    assign b_ready  = grant[1];
    assign xfer_a   = a_valid && grant[0];
    assign xfer_b   = b_valid && grant[1];
    assign xfer_any = xfer_a || xfer_b;

    // Next command and tag values; rw falls back to read whenever nothing transfers.
    always_comb begin
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        ram_rw_d    = RAM_READ;
        s1_vld_d    = xfer_any;
        s1_own_d    = REQ_A;
        s1_rd_d     = 1'b0;
        if (xfer_b) begin
            ram_addr_d  = b_addr;
            ram_wdata_d = b_wdata;
            ram_rw_d    = b_we ? RAM_WRITE : RAM_READ;
            s1_own_d    = REQ_B;
            s1_rd_d     = !b_we;
        end else if (xfer_a) begin
            ram_addr_d  = a_addr;
            ram_wdata_d = a_wdata;
            ram_rw_d    = a_we ? RAM_WRITE : RAM_READ;
            s1_own_d    = REQ_A;
            s1_rd_d     = !a_we;
        end
        s2_vld_d = s1_vld_q;
        s2_own_d = s1_own_q;
        s2_rd_d  = s1_rd_q;
    end

    // Command register and tag pipeline; reset drops anything in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            ram_rw_q    <= RAM_READ;
            s1_vld_q    <= 1'b0;
            s1_own_q    <= REQ_A;
            s1_rd_q     <= 1'b0;
            s2_vld_q    <= 1'b0;
            s2_own_q    <= REQ_A;
            s2_rd_q     <= 1'b0;
        end else begin
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            ram_rw_q    <= ram_rw_d;
            s1_vld_q    <= s1_vld_d;
            s1_own_q    <= s1_own_d;
            s1_rd_q     <= s1_rd_d;
            s2_vld_q    <= s2_vld_d;
            s2_own_q    <= s2_own_d;
            s2_rd_q     <= s2_rd_d;
        end
    end

    assign ram_addr  = ram_addr_q;
    assign ram_rw    = ram_rw_q;
    assign ram_wdata = ram_wdata_q;

    // Read data is a pass-through of the RAM output, qualified by the strobe.
    assign a_rd_valid = s2_vld_q && s2_rd_q && (s2_own_q == REQ_A);
    assign b_rd_valid = s2_vld_q && s2_rd_q && (s2_own_q == REQ_B);
    assign a_rd_data  = ram_rdata;
    assign b_rd_data  = ram_rdata;

endmodule : ram_arbiter

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural 1024x8 synchronous RAM.
module tb_ram_arbiter;

    localparam int AW = 10;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          a_valid, a_ready, a_we, a_rd_valid;
    logic [AW-1:0] a_addr;
    logic [DW-1:0] a_wdata, a_rd_data;
    logic          b_valid, b_ready, b_we, b_rd_valid;
    logic [AW-1:0] b_addr;
    logic [DW-1:0] b_wdata, b_rd_data;
    logic [AW-1:0] ram_addr;
    logic          ram_rw;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;

    logic [DW-1:0] mem [0:(1<<AW)-1];

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    ram_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .a_valid    (a_valid),
        .a_ready    (a_ready),
        .a_we       (a_we),
        .a_addr     (a_addr),
        .a_wdata    (a_wdata),
        .a_rd_valid (a_rd_valid),
        .a_rd_data  (a_rd_data),
        .b_valid    (b_valid),
        .b_ready    (b_ready),
        .b_we       (b_we),
        .b_addr     (b_addr),
        .b_wdata    (b_wdata),
        .b_rd_valid (b_rd_valid),
        .b_rd_data  (b_rd_data),
        .ram_addr   (ram_addr),
        .ram_rw     (ram_rw),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata)
    );

    // Single-port RAM: writes when rw=0, registered read otherwise.
    always @(posedge clk) begin
        if (ram_rw == 1'b0) mem[ram_addr] <= ram_wdata;
        else                ram_rdata     <= mem[ram_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        else             passed++;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        a_valid = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0;
        b_valid = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = i[7:0];
        ram_rdata = '0;
        idle_inputs();

        // Reset: a write requested during reset must not be accepted.
        rst = 1'b1;
        a_valid = 1'b1; a_we = 1'b1; a_addr = 10'h005; a_wdata = 8'hFF;
        @(negedge clk);
        check("ready_a_in_reset", a_ready, 0);
        check("ready_b_in_reset", b_ready, 0);
        next_cycle();
        @(negedge clk);
        check("rst_ram_rw", ram_rw, 1);
        check("rst_ram_addr", ram_addr, 0);
        check("rst_ram_wdata", ram_wdata, 0);
        check("rst_a_rd_valid", a_rd_valid, 0);
        check("rst_b_rd_valid", b_rd_valid, 0);
        next_cycle();
        rst = 1'b0;
        idle_inputs();

        // Idle: RAM is only ever read, nothing is returned.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check($sformatf("idle_rw_%0d", i), ram_rw, 1);
            check($sformatf("idle_rdv_%0d", i), {a_rd_valid, b_rd_valid}, 2'b00);
            next_cycle();
        end
        check("idle_mem_005", mem[10'h005], 8'h05);
        check("idle_mem_3ff", mem[10'h3FF], 8'hFF);

        // A writes 0x5A at the top address, then reads it back.
        a_valid = 1'b1; a_we = 1'b1; a_addr = 10'h3FF; a_wdata = 8'h5A;
        @(negedge clk);
        check("wr_a_ready", a_ready, 1);
        next_cycle();
        a_we = 1'b0;
        @(negedge clk);
        check("rd_a_ready", a_ready, 1);
        check("wr_pins_rw", ram_rw, 0);
        check("wr_pins_addr", ram_addr, 10'h3FF);
        check("wr_pins_data", ram_wdata, 8'h5A);
        next_cycle();
        idle_inputs();
        @(negedge clk);
        check("rd_pins_rw", ram_rw, 1);
        check("rd_lat1_a_rdv", a_rd_valid, 0);
        next_cycle();
        @(negedge clk);
        check("rd_a_rdv", a_rd_valid, 1);
        check("rd_a_data", a_rd_data, 8'h5A);
        check("rd_b_rdv", b_rd_valid, 0);
        next_cycle();
        @(negedge clk);
        check("rd_a_strobe_end", a_rd_valid, 0);
        next_cycle();

        // Continuous read contention after reset: strict A,B,A,B alternation.
        do_reset();
        mem[10'h010] = 8'h11;
        mem[10'h020] = 8'h22;
        for (int i = 0; i < 8; i++) begin
            a_valid = (i < 6); a_we = 1'b0; a_addr = 10'h010;
            b_valid = (i < 6); b_we = 1'b0; b_addr = 10'h020;
            @(negedge clk);
            if (i < 6) begin
                check($sformatf("rr_a_ready_%0d", i), a_ready, ((i % 2) == 0));
                check($sformatf("rr_b_ready_%0d", i), b_ready, ((i % 2) == 1));
            end
            if (i >= 2) begin
                check($sformatf("rr_a_rdv_%0d", i), a_rd_valid, ((i % 2) == 0));
                check($sformatf("rr_b_rdv_%0d", i), b_rd_valid, ((i % 2) == 1));
                check($sformatf("rr_data_%0d", i), ram_rdata, ((i % 2) == 0) ? 8'h11 : 8'h22);
            end else begin
                check($sformatf("rr_no_rdv_%0d", i), {a_rd_valid, b_rd_valid}, 2'b00);
            end
            next_cycle();
        end
        idle_inputs();

        // B holds a write to 0x000 while A streams reads of 0x000 (B won last).
        for (int i = 0; i < 6; i++) begin
            a_valid = (i < 4); a_we = 1'b0; a_addr = 10'h000;
            b_valid = (i < 2); b_we = 1'b1; b_addr = 10'h000; b_wdata = 8'hC3;
            @(negedge clk);
            case (i)
                0: begin
                    check("wb_c0_a_ready", a_ready, 1);
                    check("wb_c0_b_ready", b_ready, 0);
                end
                1: begin
                    check("wb_c1_b_ready", b_ready, 1);
                    check("wb_c1_a_ready", a_ready, 0);
                end
                2: begin
                    check("wb_c2_a_ready", a_ready, 1);
                    check("wb_c2_rw", ram_rw, 0);
                    check("wb_c2_wdata", ram_wdata, 8'hC3);
                    check("wb_c2_a_rdv", a_rd_valid, 1);
                    check("wb_c2_old", a_rd_data, 8'h00);
                end
                3: begin
                    check("wb_c3_a_ready", a_ready, 1);
                    check("wb_c3_no_rdv", {a_rd_valid, b_rd_valid}, 2'b00);
                end
                default: begin
                    check($sformatf("wb_c%0d_a_rdv", i), a_rd_valid, 1);
                    check($sformatf("wb_c%0d_new", i), a_rd_data, 8'hC3);
                    check($sformatf("wb_c%0d_b_rdv", i), b_rd_valid, 0);
                end
            endcase
            next_cycle();
        end
        idle_inputs();

        // Reset one cycle after a read is accepted; a write offered during reset is dropped.
        a_valid = 1'b1; a_we = 1'b0; a_addr = 10'h3FF;
        @(negedge clk);
        check("mr_a_ready", a_ready, 1);
        next_cycle();
        a_valid = 1'b0;
        rst = 1'b1;
        b_valid = 1'b1; b_we = 1'b1; b_addr = 10'h3FF; b_wdata = 8'hEE;
        @(negedge clk);
        check("mr_b_ready_in_rst", b_ready, 0);
        next_cycle();
        rst = 1'b0;
        a_valid = 1'b1; a_we = 1'b0; a_addr = 10'h010;
        b_valid = 1'b1; b_we = 1'b0; b_addr = 10'h020;
        @(negedge clk);
        check("mr_no_a_rdv", a_rd_valid, 0);
        check("mr_rw_after_rst", ram_rw, 1);
        check("mr_a_wins", a_ready, 1);
        check("mr_b_waits", b_ready, 0);
        next_cycle();
        idle_inputs();
        @(negedge clk);
        check("mr_rd_rw", ram_rw, 1);
        check("mr_rd_addr", ram_addr, 10'h010);
        next_cycle();
        @(negedge clk);
        check("mr_a_rdv", a_rd_valid, 1);
        check("mr_a_data", a_rd_data, 8'h11);
        check("mr_write_dropped", mem[10'h3FF], 8'h5A);
        next_cycle();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule : tb_ram_arbiter

// File: doc/ram_arbiter.md
# ram_arbiter

Shares the single-port 1024x8 block RAM between two requesters, A and B, using round-robin arbitration. Each requester uses a valid/ready command handshake. The arbiter registers the winning command onto the RAM `addr`/`rw`/`data_in` pins and returns read data to the original requester with a `rd_valid` strobe. It sits between the RAM and its producers/consumers, such as a sample writer and a playback reader.

## Interface
- `AW`, 10, RAM address width (1024 locations)
- `DW`, 8, RAM data width
- `clk` in 1 — global clock; all logic on rising edge
- `rst` in 1 — synchronous, active-high reset
- `a_valid` in 1 — requester A command valid
- `a_ready` out 1 — A command accepted this cycle
- `a_we` in 1 — 1 = write, 0 = read
- `a_addr` in AW — A address
- `a_wdata` in DW — A write data
- `a_rd_valid` out 1 — A read data valid (one-cycle strobe)
- `a_rd_data` out DW — A read data
- `b_*` — same seven signals for requester B
- `ram_addr` out AW — to RAM `addr`
- `ram_rw` out 1 — to RAM `rw`; 1 = read, 0 = write
- `ram_wdata` out DW — to RAM `data_in`
- `ram_rdata` in DW — from RAM `data_out`

## Operation
- Transfer occurs on A when `a_valid && a_ready` (same for B). At most one transfer per cycle.
- Grant is combinational from the valid signals and the `last` pointer:
  - Only one requester valid → that requester is granted.
  - Both valid → grant the requester that is not `last`.
  - `last` updates only on a transfer.
- `x_ready` = grant. Requesters hold `x_valid` and command fields stable until ready. Ready never depends on the other requester's ready.
- Command stage (registered):
  - On transfer, load `ram_addr`, `ram_wdata` and `ram_rw` (= ~we).
  - With no transfer: `ram_rw`=1 (harmless read), `ram_addr`/`ram_wdata` hold.
  - The RAM writes whenever rw=0, so `ram_rw` must never be 0 without a transfer in the previous cycle.
- Tag pipeline: `s1_{vld,own,rd}` is registered with the command stage; `s2` follows one cycle later. `x_rd_valid` = `s2_vld && s2_rd && s2_own==x`. `x_rd_data` = `ram_rdata` (unregistered pass-through, valid only with the strobe).
- Writes produce no response.
- Addresses are AW bits wide. No wrap logic is needed; all 2^AW locations are legal.

## Timing
- Reset values:
  - `ram_rw`=1, `ram_addr`=0, `ram_wdata`=0
  - `a_rd_valid`=`b_rd_valid`=0
  - s1/s2 valids=0
  - `last`=B, so A wins the first contention
  - `x_ready` is 0 while `rst`=1
- Read: accepted in cycle N → RAM pins driven in N+1 → RAM samples at end of N+1 → `x_rd_valid` high in N+2. Fixed latency of 2; no backpressure on read data.
- Write: accepted in N → RAM written at end of N+1.
- Throughput: one access per cycle, fully pipelined. Under continuous contention the grant strictly alternates A,B,A,B.
- Write-then-read to the same address in consecutive transfers returns the new data (the write lands one edge before the read samples).
- Reset mid-operation:
  - In-flight tags are cleared; no `rd_valid` for reads accepted before reset.
  - `ram_rw` is forced to 1 in the cycle after reset asserts.
  - A write accepted in the cycle reset asserts is dropped.
  - RAM contents are not cleared.

## Structure
- Package `ram_arb_pkg`:
  - AW/DW defaults
  - `RAM_READ`=1'b1, `RAM_WRITE`=1'b0
  - requester id encoding `REQ_A`=1'b0, `REQ_B`=1'b1
- Sub-module `rr_grant2`: two-input round-robin grant with a `last` register. Inputs: valid pair, accept. Output: one-hot grant.
- The command register and the two-deep tag pipeline stay in `ram_arbiter`.

## Test plan
- Reset, then idle 10 cycles → `ram_rw`=1 every cycle, no `rd_valid`, RAM contents unchanged.
- A writes 0x5A @0x3FF in cycle 2, then A reads @0x3FF in cycle 3 → `a_rd_valid` in cycle 5 with 0x5A; `b_rd_valid` stays 0.
- A and B both hold valid reads for 6 cycles (A@0x010, B@0x020, preloaded 0x11/0x22) → grants A,B,A,B,A,B; `rd_data` alternates 0x11/0x22, each 2 cycles after its grant.
- B holds a write 0xC3 @0x000 while A streams reads of @0x000 → B is accepted within 2 cycles; A's reads issued after B's write return 0xC3.
- A read accepted in cycle N, `rst` pulsed in N+1 → no `a_rd_valid` in N+2; `ram_rw`=1; A wins the first post-reset contention.
